adc_dac_loop: RTL and testbench
===============================

ADC_DAC_LOOP -- requirements
Module: adc_dac_loop

Interface
REQ-001 Parameter DATA_W, default 14: width of ADC input and DAC output codes (unsigned offset-binary).
REQ-002 Parameter DEPTH, default 16: delay-line entries, power of two, >= 2.
REQ-003 Parameter CNT_W, default 16: width of the saturation event counter.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-006 ADC_A  input  DATA_W  ADC sample code.
REQ-007 loop_mode  input  2  00 = pass-through, 01 = ramp test, 10 = hold, 11 = mid-scale.
REQ-008 dly  input  log2(DEPTH)  extra delay in cycles, 0..DEPTH-1.
REQ-009 offset  input  DATA_W+1  signed two's-complement correction added to each sample.
REQ-010 sat_clr  input  1  synchronous clear of the saturation counter.
REQ-011 DAC_A  output  DATA_W  registered DAC code.
REQ-012 sat_cnt  output  CNT_W  number of clipped samples.
REQ-013 sat_flag  output  1  high when sat_cnt != 0.
REQ-014 mode  output  1  ADC mode pin, constant 1.
REQ-015 dac_clk_A, adc_clk_A, dac_wrt_A  output  1 each  direct copies of clk.
REQ-016 adc_en_A  output  1  ADC output enable, constant 0 (active-low enable, always enabled).

Function
REQ-017 Stage 1 shall register ADC_A every cycle into adc_q.
REQ-018 Stage 2 shall compute adc_q + offset at DATA_W+2 bits signed.
- Result < 0 clips to 0.
- Result > 2^DATA_W-1 clips to 2^DATA_W-1.
- The clipped value is registered as corr_q.
REQ-019 A clip in stage 2 shall increment sat_cnt by 1 on the same edge that corr_q is registered.
- The increment saturates at 2^CNT_W-1 (no wrap).
REQ-020 sat_clr shall zero sat_cnt on the next edge; sat_clr has priority over a simultaneous increment.
REQ-021 The delay line shall be a DEPTH-entry circular buffer.
- corr_q is written at wr_ptr every cycle.
- wr_ptr increments modulo DEPTH.
REQ-022 The read index shall be (wr_ptr - dly) modulo DEPTH.
- The entry read is the value being written when dly = 0 (bypass).
- Read data is registered into DAC_A.
REQ-023 Pass-through latency shall be: ADC_A sampled at edge k appears on DAC_A after edge k+2+dly.
REQ-024 A change of dly shall take effect on the next edge without flushing the buffer; the output may skip or repeat samples during the change.
REQ-025 Ramp mode shall drive DAC_A from an internal counter.
- The counter starts at 0 on the first edge in ramp mode and increments by 1 per cycle.
- It wraps from 2^DATA_W-1 to 0.
- Re-entering ramp mode restarts the counter at 0.
REQ-026 Hold mode shall keep DAC_A at its current value.
- The pipeline, delay line and sat_cnt keep running.
REQ-027 Mid-scale mode shall drive DAC_A = 2^(DATA_W-1) on the next edge.
REQ-028 loop_mode shall be sampled every edge.
- The new source drives DAC_A on the edge at which the new mode is first sampled.
- Returning to pass-through immediately outputs the current delay-line read.

Reset
REQ-029 While reset = 0 at a rising edge, the following reset values shall apply:
- adc_q = 0, corr_q = 0.
- All delay-line entries = 2^(DATA_W-1); DAC_A = 2^(DATA_W-1).
- wr_ptr = 0, ramp counter = 0.
- sat_cnt = 0, sat_flag = 0.
REQ-030 Reset asserted mid-operation shall override every mode and sat_clr on that edge.
REQ-031 Normal operation shall resume on the first edge with reset = 1.
- Pass-through output shows mid-scale until real samples propagate through the pipeline.

Verification
REQ-032 Reset, then ADC_A = 0x1234, offset = 0, dly = 0, mode 00 -> DAC_A = 0x2000 until edge 2; DAC_A = 0x1234 after edge 2.
REQ-033 Ramp ADC_A +1 per cycle, dly = 5 -> DAC_A equals ADC_A delayed 7 cycles; mid-scale shown for the first 7 outputs.
REQ-034 ADC_A = 0x3FF0, offset = +0x20 for 10 cycles -> DAC_A = 0x3FFF, sat_cnt = 10; sat_clr pulse -> sat_cnt = 0, sat_flag = 0.
REQ-035 ADC_A = 0x0005, offset = -8 -> DAC_A = 0; sat_cnt increments; sat_clr asserted in the same cycle as a clip -> sat_cnt = 0.
REQ-036 Mode sequence 01 for 20 cycles, then 10, then 11, then 01:
- DAC_A counts 0..19 during the first ramp.
- Hold shows 19.
- Mid-scale shows 0x2000.
- The second ramp restarts at 0.
- Check ramp wrap 0x3FFF -> 0.
REQ-037 reset = 0 for one cycle mid-ramp with sat_cnt = 3 -> DAC_A = 0x2000, sat_cnt = 0, ramp counter = 0 on that edge.

Source files
------------

// File: rtl/adc_dac_loop.sv
// ADC-to-DAC loop: register, offset-correct with clipping, programmable delay line, then DAC mux (pass/ramp/hold/mid).
// Pass-through latency 2+dly cycles; free-running every cycle with no backpressure.
module adc_dac_loop #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        ADC_A,
  input  logic [1:0]               loop_mode,
  input  logic [$clog2(DEPTH)-1:0] dly,
  input  logic [DATA_W:0]          offset,
  input  logic                     sat_clr,
  output logic [DATA_W-1:0]        DAC_A,
  output logic [CNT_W-1:0]         sat_cnt,
  output logic                     sat_flag,
  output logic                     mode,
  output logic                     dac_clk_A,
  output logic                     adc_clk_A,
  output logic                     dac_wrt_A,
  output logic                     adc_en_A
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_RAMP = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b10;
  localparam logic [1:0] MODE_MID  = 2'b11;

  localparam logic [DATA_W-1:0] MID     = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] FULL    = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [DATA_W-1:0]        adc_q;
  logic [DATA_W-1:0]        corr_q;
  logic [DATA_W-1:0]        corr_d;
  logic [DATA_W-1:0]        wr_dat;
  logic [DATA_W-1:0]        rd_dat;
  logic [DATA_W-1:0]        ramp_cnt;
  logic [DATA_W-1:0]        ramp_nxt;
  logic                     adc_vld;
  logic                     corr_vld;
  logic                     ramp_q;
  logic                     clip;
  logic signed [DATA_W+1:0] sum;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [DATA_W-1:0]        mem [DEPTH];

  always_comb begin
    sum    = $signed({2'b00, adc_q}) + $signed({offset[DATA_W], offset});
    clip   = 1'b0;
    corr_d = sum[DATA_W-1:0];
    if (sum[DATA_W+1]) begin
      corr_d = '0;
      clip   = 1'b1;
    end else if (sum[DATA_W]) begin
      corr_d = FULL;
      clip   = 1'b1;
    end
  end

  // Bubbles left by reset enter the delay line as mid-scale, not as the zeroed pipeline regs.
  assign wr_dat   = corr_vld ? corr_q : MID;
  assign rd_ptr   = wr_ptr - dly;
  assign rd_dat   = (dly == '0) ? wr_dat : mem[rd_ptr];
  assign ramp_nxt = ramp_q ? ramp_cnt + DATA_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      adc_q    <= '0;
      corr_q   <= '0;
      adc_vld  <= 1'b0;
      corr_vld <= 1'b0;
      wr_ptr   <= '0;
      ramp_cnt <= '0;
      ramp_q   <= 1'b0;
      sat_cnt  <= '0;
      DAC_A    <= MID;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= MID;
      end
    end else begin
      adc_q       <= ADC_A;
      adc_vld     <= 1'b1;
      corr_q      <= corr_d;
      corr_vld    <= adc_vld;
      mem[wr_ptr] <= wr_dat;
      wr_ptr      <= wr_ptr + PTR_W'(1);
      ramp_q      <= (loop_mode == MODE_RAMP);

      if (sat_clr) begin
        sat_cnt <= '0;
      end else if (clip && adc_vld && (sat_cnt != CNT_MAX)) begin
        sat_cnt <= sat_cnt + CNT_W'(1);
      end

      case (loop_mode)
        MODE_PASS: DAC_A <= rd_dat;
        MODE_RAMP: begin
          DAC_A    <= ramp_nxt;
          ramp_cnt <= ramp_nxt;
        end
        MODE_HOLD: DAC_A <= DAC_A;
        MODE_MID:  DAC_A <= MID;
        default:   DAC_A <= MID;
      endcase
    end
  end

  assign sat_flag  = (sat_cnt != '0);
  assign mode      = 1'b1;
  assign dac_clk_A = clk;
  assign adc_clk_A = clk;
  assign dac_wrt_A = clk;
  assign adc_en_A  = 1'b0;

endmodule

// File: tb/tb_adc_dac_loop.sv
// Randomized and directed bench for adc_dac_loop against a per-edge history model.
module tb_adc_dac_loop;

  localparam int MID  = 8192;
  localparam int MAXV = 16383;
  localparam int HIST = 32768;

  logic        clk;
  logic        reset;
  logic [13:0] ADC_A;
  logic [1:0]  loop_mode;
  logic [3:0]  dly;
  logic [14:0] offset;
  logic        sat_clr;
  logic [13:0] DAC_A;
  logic [15:0] sat_cnt;
  logic        sat_flag;
  logic        mode;
  logic        dac_clk_A;
  logic        adc_clk_A;
  logic        dac_wrt_A;
  logic        adc_en_A;

  int checks = 0;
  int errors = 0;

  // Model: sample history indexed by edge number since the last reset.
  int adc_h [HIST];
  int off_h [HIST];
  int n = 0;
  int m_dac = MID;
  int m_sat = 0;
  int m_ramp = 0;
  bit m_prev_ramp = 0;

  adc_dac_loop dut (
    .clk(clk), .reset(reset), .ADC_A(ADC_A), .loop_mode(loop_mode), .dly(dly),
    .offset(offset), .sat_clr(sat_clr), .DAC_A(DAC_A), .sat_cnt(sat_cnt),
    .sat_flag(sat_flag), .mode(mode), .dac_clk_A(dac_clk_A), .adc_clk_A(adc_clk_A),
    .dac_wrt_A(dac_wrt_A), .adc_en_A(adc_en_A)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int clip(int v);
    if (v < 0) return 0;
    if (v > MAXV) return MAXV;
    return v;
  endfunction

  // One rising edge; the model advances from the inputs present at that edge.
  task automatic tick();
    int w;
    int v;
    if (reset && n < HIST) begin
      adc_h[n] = int'(ADC_A);
      off_h[n] = int'($signed(offset));
    end
    @(posedge clk);
    if (!reset) begin
      n = 0;
      m_dac = MID;
      m_sat = 0;
      m_ramp = 0;
      m_prev_ramp = 0;
    end else begin
      if (sat_clr) begin
        m_sat = 0;
      end else if (n >= 1) begin
        v = adc_h[n-1] + off_h[n];
        if ((v < 0 || v > MAXV) && m_sat < 65535) m_sat++;
      end
      case (loop_mode)
        2'b00: begin
          w = n - int'(dly);
          m_dac = (w < 2) ? MID : clip(adc_h[w-2] + off_h[w-1]);
        end
        2'b01: begin
          m_ramp = m_prev_ramp ? (m_ramp + 1) % 16384 : 0;
          m_dac = m_ramp;
        end
        2'b10: ;
        default: m_dac = MID;
      endcase
      m_prev_ramp = (loop_mode == 2'b01);
      n++;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sat_clr = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ADC_A = 14'h1abc;
    loop_mode = 2'b10;
    dly = 4'd3;
    offset = 15'h7f00;
    sat_clr = 1'b0;
    tick();
    tick();
    checks++;
    if (DAC_A !== 14'h2000) begin errors++; $display("FAIL reset_dac got %h exp 2000", DAC_A); end
    checks++;
    if (sat_cnt !== 16'd0) begin errors++; $display("FAIL reset_sat_cnt got %0d exp 0", sat_cnt); end
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got %b exp 0", sat_flag); end
    checks++;
    if (mode !== 1'b1 || adc_en_A !== 1'b0) begin
      errors++; $display("FAIL static_pins got mode=%b adc_en=%b exp mode=1 adc_en=0", mode, adc_en_A);
    end
    checks++;
    if (dac_clk_A !== clk || adc_clk_A !== clk || dac_wrt_A !== clk) begin
      errors++; $display("FAIL clk_copies got %b%b%b exp %b", dac_clk_A, adc_clk_A, dac_wrt_A, clk);
    end
    #5;
    checks++;
    if (dac_clk_A !== clk || adc_clk_A !== clk || dac_wrt_A !== clk) begin
      errors++; $display("FAIL clk_copies_low got %b%b%b exp %b", dac_clk_A, adc_clk_A, dac_wrt_A, clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_passthrough();
    int exp_v;
    do_reset();
    ADC_A = 14'h1234;
    offset = 15'd0;
    dly = 4'd0;
    loop_mode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_v = (i < 2) ? 'h2000 : 'h1234;
      checks++;
      if (DAC_A !== 14'(exp_v)) begin errors++; $display("FAIL pass_edge%0d got %h exp %h", i, DAC_A, exp_v); end
    end
  endtask

  task automatic test_delay();
    int a;
    int exp_v;
    do_reset();
    dly = 4'd5;
    offset = 15'd0;
    loop_mode = 2'b00;
    a = $urandom_range(0, MAXV - 64);
    for (int i = 0; i < 30; i++) begin
      ADC_A = 14'(a + i);
      tick();
      exp_v = (i < 7) ? MID : a + i - 7;
      checks++;
      if (DAC_A !== 14'(exp_v) || DAC_A !== 14'(m_dac)) begin
        errors++; $display("FAIL delay5_edge%0d got %h exp %h", i, DAC_A, exp_v);
      end
    end
  endtask

  task automatic test_sat_high();
    do_reset();
    ADC_A = 14'h3ff0;
    offset = 15'h0020;
    dly = 4'd0;
    loop_mode = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 2) begin
        checks++;
        if (DAC_A !== 14'h3fff) begin errors++; $display("FAIL sat_hi_dac got %h exp 3fff", DAC_A); end
      end
    end
    ADC_A = 14'h0100;
    tick();
    tick();
    tick();
    checks++;
    if (sat_cnt !== 16'd10 || sat_cnt !== 16'(m_sat) || sat_flag !== 1'b1) begin
      errors++; $display("FAIL sat_hi_cnt got %0d/%b exp 10/1", sat_cnt, sat_flag);
    end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    checks++;
    if (sat_cnt !== 16'd0 || sat_flag !== 1'b0) begin
      errors++; $display("FAIL sat_clr got %0d/%b exp 0/0", sat_cnt, sat_flag);
    end
  endtask

  task automatic test_sat_low();
    do_reset();
    ADC_A = 14'h0005;
    offset = 15'h7ff8;
    dly = 4'd0;
    loop_mode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (sat_cnt !== 16'(i) || sat_cnt !== 16'(m_sat)) begin
        errors++; $display("FAIL sat_lo_cnt%0d got %0d exp %0d", i, sat_cnt, i);
      end
      if (i >= 2) begin
        checks++;
        if (DAC_A !== 14'd0) begin errors++; $display("FAIL sat_lo_dac got %h exp 0", DAC_A); end
      end
    end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    checks++;
    if (sat_cnt !== 16'd0) begin errors++; $display("FAIL sat_clr_prio got %0d exp 0", sat_cnt); end
    tick();
    checks++;
    if (sat_cnt !== 16'd1 || sat_cnt !== 16'(m_sat)) begin
      errors++; $display("FAIL sat_after_clr got %0d exp 1", sat_cnt);
    end
  endtask

  task automatic test_modes();
    do_reset();
    ADC_A = 14'($urandom);
    offset = 15'd0;
    dly = 4'd2;
    loop_mode = 2'b01;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (DAC_A !== 14'(i)) begin errors++; $display("FAIL ramp1_%0d got %0d exp %0d", i, DAC_A, i); end
    end
    loop_mode = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (DAC_A !== 14'd19) begin errors++; $display("FAIL hold got %0d exp 19", DAC_A); end
    end
    loop_mode = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (DAC_A !== 14'h2000) begin errors++; $display("FAIL midscale got %h exp 2000", DAC_A); end
    end
    loop_mode = 2'b01;
    for (int i = 0; i < 16390; i++) begin
      tick();
      checks++;
      if (DAC_A !== 14'(i % 16384) || DAC_A !== 14'(m_dac)) begin
        errors++; $display("FAIL ramp2_%0d got %0d exp %0d", i, DAC_A, i % 16384);
      end
    end
    loop_mode = 2'b00;
    tick();
    checks++;
    if (DAC_A !== 14'(m_dac)) begin errors++; $display("FAIL back_to_pass got %h exp %h", DAC_A, m_dac); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ADC_A = 14'd0;
    offset = 15'd0;
    dly = 4'd0;
    loop_mode = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    offset = 15'h7fff;
    for (int i = 0; i < 3; i++) tick();
    offset = 15'd0;
    tick();
    checks++;
    if (sat_cnt !== 16'd3) begin errors++; $display("FAIL pre_reset_sat got %0d exp 3", sat_cnt); end
    reset = 1'b0;
    loop_mode = 2'b10;
    sat_clr = 1'b1;
    tick();
    checks++;
    if (DAC_A !== 14'h2000 || sat_cnt !== 16'd0 || sat_flag !== 1'b0) begin
      errors++; $display("FAIL mid_reset got dac=%h sat=%0d flag=%b exp 2000/0/0", DAC_A, sat_cnt, sat_flag);
    end
    reset = 1'b1;
    sat_clr = 1'b0;
    loop_mode = 2'b01;
    tick();
    checks++;
    if (DAC_A !== 14'd0) begin errors++; $display("FAIL ramp_after_reset got %0d exp 0", DAC_A); end
    tick();
    checks++;
    if (DAC_A !== 14'd1) begin errors++; $display("FAIL ramp_after_reset1 got %0d exp 1", DAC_A); end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    loop_mode = 2'b00;
    dly = 4'($urandom_range(0, 15));
    offset = 15'($urandom_range(0, 1200) - 600);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) ADC_A = 14'($urandom_range(0, 20));
      else if (r == 1) ADC_A = 14'($urandom_range(MAXV - 20, MAXV));
      else ADC_A = 14'($urandom);
      if ($urandom_range(0, 7) == 0) offset = 15'($urandom_range(0, 1200) - 600);
      if ($urandom_range(0, 15) == 0) dly = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) loop_mode = 2'($urandom_range(0, 3));
      else if ($urandom_range(0, 9) == 0) loop_mode = 2'b00;
      sat_clr = ($urandom_range(0, 24) == 0);
      tick();
      checks++;
      if (DAC_A !== 14'(m_dac)) begin errors++; $display("FAIL rand_dac%0d got %h exp %h", i, DAC_A, m_dac); end
      checks++;
      if (sat_cnt !== 16'(m_sat) || sat_flag !== (m_sat != 0)) begin
        errors++; $display("FAIL rand_sat%0d got %0d/%b exp %0d", i, sat_cnt, sat_flag, m_sat);
      end
    end
    sat_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    ADC_A = '0;
    loop_mode = 2'b00;
    dly = '0;
    offset = '0;
    sat_clr = 1'b0;
    test_reset();
    test_passthrough();
    test_delay();
    test_sat_high();
    test_sat_low();
    test_modes();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
